pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core. Merges stage stall requests into the
//  stall[5:0] vector that drives pc_reg and the inter-stage registers (if_id, id_ex, ...).
//  Sequences multi-cycle EX operations (div, madd) with an internal cycle counter.
//  Turns exception requests into a registered flush pulse carrying the redirect PC.
// PARAMETERS
//  CNT_W       6   width of multi-cycle length field / counter
//  FLUSH_HOLD  1   cycles flush stays high per exception (>=1)
//  ADDR_W      32  width of PC / new_pc
// PORTS
//  clk           in   1       core clock, rising edge
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  stallreq_if   in   1       IF waiting on instruction bus
//  stallreq_id   in   1       ID load-use hazard
//  stallreq_ex   in   1       EX single-cycle stall
//  stallreq_mem  in   1       MEM waiting on data bus
//  mc_start      in   1       EX begins multi-cycle op this cycle
//  mc_cycles     in   CNT_W   length N of that op in cycles (0 treated as 1)
//  exception_i   in   1       MEM-stage exception commit
//  new_pc_i      in   ADDR_W  handler address, valid with exception_i
//  stall         out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold
//  mc_done       out  1       final stall cycle of a multi-cycle op
//  mc_abort      out  1       multi-cycle op killed by exception (1 cycle)
//  flush         out  1       clear all inter-stage registers, redirect PC
//  new_pc        out  ADDR_W  redirect address, valid while flush=1
//  stall_cycles  out  32      saturating count of cycles with stall[0]=1
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, cnt=0, flush=0, new_pc=0, stall_cycles=0;
//   stall, mc_done, mc_abort forced 0.
//  Stall encoding: request of stage k holds stages 0..k:
//   IF=6'b000011, ID=6'b000111, EX=6'b001111, MEM=6'b011111; stall = OR of active codes.
//   Combinational from inputs + state (zero latency); WB never stalls (stall[5]=0).
//  States RUN, MC_BUSY, FLUSH.
//  RUN:
//   - exception_i=1: highest priority; stall=0 this cycle; ->FLUSH, capture new_pc_i.
//   - else mc_start=1: EX code asserted this cycle; Neff=max(N,1).
//     Neff=1 -> mc_done=1 this cycle, stay RUN. Neff>1 -> cnt<=Neff-1, ->MC_BUSY.
//   - else stall from stallreq_* only.
//  MC_BUSY: stall >= EX code (MEM request widens to MEM code); mc_start ignored.
//   - each cycle cnt<=cnt-1; cnt==1 -> mc_done=1, ->RUN. Total EX stall = Neff cycles.
//   - exception_i=1: mc_abort=1, stall=0, cnt<=0, ->FLUSH (mc_done not asserted).
//  FLUSH: flush=1 and new_pc held for FLUSH_HOLD cycles starting cycle after exception;
//   stall=0, all stallreq_*/mc_start ignored; then ->RUN.
//   exception_i during FLUSH: recapture new_pc_i, restart hold count.
//  stall_cycles: +1 each cycle stall[0]=1; saturates at 32'hFFFF_FFFF, no wrap.
//  Reset mid-operation: immediate return to reset values; pending op/flush dropped.
// TESTING
//  1 stallreq_id=1 one cycle in RUN -> stall=6'b000111 same cycle, 0 next; stall_cycles=1.
//  2 stallreq_if+stallreq_mem together -> stall=6'b011111.
//  3 mc_start, mc_cycles=5 -> stall=6'b001111 exactly 5 cycles, mc_done only in 5th, then 0.
//  4 mc_cycles=0 and =1 -> 1 stall cycle, mc_done same cycle, state stays RUN.
//  5 exception_i, new_pc_i=32'h0000_0020 in MC_BUSY cycle 3 -> mc_abort=1, stall=0;
//    next cycle flush=1, new_pc=32'h20; stallreq_ex during flush ignored.
//  6 rst=0 asserted mid MC_BUSY between edges -> all outputs 0 immediately;
//    stall_cycles preloaded near max -> holds 32'hFFFF_FFFF under continued stall.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences multi-cycle EX ops,
// and converts exceptions into a registered flush pulse with a redirect PC.
module pipe_ctrl #(
    parameter int CNT_W      = 6,
    parameter int FLUSH_HOLD = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic [CNT_W-1:0]  mc_cycles,
    input  logic              exception_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [5:0]        stall,
    output logic              mc_done,
    output logic              mc_abort,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic [31:0]       stall_cycles
);

    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FLUSH_HOLD - 1);

    localparam logic [5:0] CODE_IF  = 6'b000011;
    localparam logic [5:0] CODE_ID  = 6'b000111;
    localparam logic [5:0] CODE_EX  = 6'b001111;
    localparam logic [5:0] CODE_MEM = 6'b011111;

    typedef enum logic [1:0] {RUN, MC_BUSY, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         stall_cycles_q, stall_cycles_d;

    logic [5:0]          req_code;
    logic [5:0]          stall_c;
    logic                done_c;
    logic                abort_c;
    logic [CNT_W-1:0]    n_eff;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        req_code = 6'b0;
        if (stallreq_if)  req_code = req_code | CODE_IF;
        if (stallreq_id)  req_code = req_code | CODE_ID;
        if (stallreq_ex)  req_code = req_code | CODE_EX;
        if (stallreq_mem) req_code = req_code | CODE_MEM;
    end

    assign n_eff = (mc_cycles == '0) ? CNT_W'(1) : mc_cycles;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        pc_d    = pc_q;
        stall_c = req_code;
        done_c  = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            RUN: begin
                if (exception_i) begin
                    stall_c = 6'b0;
                    pc_d    = new_pc_i;
                    hold_d  = HOLD_LAST;
                    state_d = FLUSH;
                end else if (mc_start) begin
                    stall_c = req_code | CODE_EX;
                    if (n_eff == CNT_W'(1)) begin
                        done_c = 1'b1;
                    end else begin
                        cnt_d   = n_eff - CNT_W'(1);
                        state_d = MC_BUSY;
                    end
                end
            end
            MC_BUSY: begin
                if (exception_i) begin
                    stall_c = 6'b0;
                    abort_c = 1'b1;
                    cnt_d   = '0;
                    pc_d    = new_pc_i;
                    hold_d  = HOLD_LAST;
                    state_d = FLUSH;
                end else begin
                    // cnt holds remaining stall cycles including this one
                    stall_c = req_code | CODE_EX;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_c  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                stall_c = 6'b0;
                if (exception_i) begin
                    pc_d   = new_pc_i;
                    hold_d = HOLD_LAST;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                stall_c = 6'b0;
                state_d = RUN;
            end
        endcase
    end

    // Combinational outputs are held low while reset is asserted
    assign stall    = rst ? stall_c : 6'b0;
    assign mc_done  = rst & done_c;
    assign mc_abort = rst & abort_c;
    assign flush    = (state_q == FLUSH);
    assign new_pc   = pc_q;
    assign stall_cycles = stall_cycles_q;

    assign stall_cycles_d = stall[0] ? sat_inc(stall_cycles_q) : stall_cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            hold_q         <= '0;
            pc_q           <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            pc_q           <= pc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expectations queued at drive time and
// popped for comparison once the cycle's outputs have settled.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sif, sid, sex, smem;
    logic        mcs;
    logic [5:0]  mcn;
    logic        exc;
    logic [31:0] npc;
    logic [5:0]  stall;
    logic        mc_done, mc_abort, flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(6), .FLUSH_HOLD(1), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (sif),
        .stallreq_id  (sid),
        .stallreq_ex  (sex),
        .stallreq_mem (smem),
        .mc_start     (mcs),
        .mc_cycles    (mcn),
        .exception_i  (exc),
        .new_pc_i     (npc),
        .stall        (stall),
        .mc_done      (mc_done),
        .mc_abort     (mc_abort),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        done;
        logic        abort;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] sc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sc_exp = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".stall"},        {26'd0, stall}, {26'd0, e.stall});
        chk({e.tag, ".mc_done"},      {31'd0, mc_done}, {31'd0, e.done});
        chk({e.tag, ".mc_abort"},     {31'd0, mc_abort}, {31'd0, e.abort});
        chk({e.tag, ".flush"},        {31'd0, flush}, {31'd0, e.flush});
        chk({e.tag, ".new_pc"},       new_pc, e.pc);
        chk({e.tag, ".stall_cycles"}, stall_cycles, e.sc);
    endtask

    // req bits: {mem, ex, id, if}
    task automatic drive(input logic rst_v, input logic [3:0] req, input logic st,
                         input logic [5:0] n, input logic ex, input logic [31:0] pc,
                         input logic [5:0] e_stall, input logic e_done, input logic e_abort,
                         input logic e_flush, input logic [31:0] e_pc, input string tag);
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        {smem, sex, sid, sif} = req;
        mcs = st;
        mcn = n;
        exc = ex;
        npc = pc;
        if (!rst_v) sc_exp = 32'd0;
        e.stall = e_stall;
        e.done  = e_done;
        e.abort = e_abort;
        e.flush = e_flush;
        e.pc    = e_pc;
        e.sc    = sc_exp;
        e.tag   = tag;
        sb.push_back(e);
        if (e_stall[0] && sc_exp != 32'hFFFF_FFFF) sc_exp = sc_exp + 32'd1;
        #2;
        compare_head();
    endtask

    initial begin
        rst = 1'b0;
        {smem, sex, sid, sif} = 4'b0;
        mcs = 1'b0; mcn = 6'd0; exc = 1'b0; npc = 32'd0;

        // reset: requests present but everything forced low
        drive(0, 4'b1111, 1, 6'd5, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "rst_hold");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "idle");

        // single-stage requests and merging
        drive(1, 4'b0010, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0, 0, 32'h0, "id");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "id_off");
        drive(1, 4'b1001, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 0, 0, 32'h0, "if_mem");
        drive(1, 4'b0100, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, "ex");

        // five-cycle op; mc_start ignored while busy, MEM request widens
        drive(1, 4'b0000, 1, 6'd5, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, "mc5_c1");
        drive(1, 4'b0000, 1, 6'd3, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, "mc5_c2");
        drive(1, 4'b1000, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 0, 0, 32'h0, "mc5_c3");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h0, "mc5_c4");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b001111, 1, 0, 0, 32'h0, "mc5_c5");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "mc5_after");

        // degenerate lengths finish in the start cycle
        drive(1, 4'b0000, 1, 6'd0, 0, 32'h0, 6'b001111, 1, 0, 0, 32'h0, "mc0");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "mc0_after");
        drive(1, 4'b0000, 1, 6'd1, 0, 32'h0, 6'b001111, 1, 0, 0, 32'h0, "mc1");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "mc1_after");

        // exception in the third busy cycle aborts the op
        drive(1, 4'b0000, 1, 6'd4, 0, 32'h0,  6'b001111, 0, 0, 0, 32'h0,  "ab_c1");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0,  6'b001111, 0, 0, 0, 32'h0,  "ab_c2");
        drive(1, 4'b0000, 0, 6'd0, 1, 32'h20, 6'b000000, 0, 1, 0, 32'h0,  "ab_exc");
        drive(1, 4'b0100, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 1, 32'h20, "ab_flush");
        drive(1, 4'b0100, 0, 6'd0, 0, 32'h0,  6'b001111, 0, 0, 0, 32'h20, "ab_run");

        // exception beats mc_start in RUN; re-exception during flush recaptures
        drive(1, 4'b0010, 1, 6'd5, 1, 32'h30, 6'b000000, 0, 0, 0, 32'h20, "exc_run");
        drive(1, 4'b0000, 0, 6'd0, 1, 32'h40, 6'b000000, 0, 0, 1, 32'h30, "exc_reflush");
        drive(1, 4'b0001, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 1, 32'h40, "exc_hold");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0,  6'b000000, 0, 0, 0, 32'h40, "exc_end");

        // asynchronous reset in the middle of a long op
        drive(1, 4'b0000, 1, 6'd10, 0, 32'h0, 6'b001111, 0, 0, 0, 32'h40, "rs_c1");
        drive(1, 4'b0100, 0, 6'd0,  0, 32'h0, 6'b001111, 0, 0, 0, 32'h40, "rs_c2");
        drive(0, 4'b0100, 0, 6'd0,  0, 32'h0, 6'b000000, 0, 0, 0, 32'h0,  "rs_async");
        drive(0, 4'b0000, 0, 6'd0,  0, 32'h0, 6'b000000, 0, 0, 0, 32'h0,  "rs_hold");
        drive(1, 4'b0000, 0, 6'd0,  0, 32'h0, 6'b000000, 0, 0, 0, 32'h0,  "rs_after");

        // counter preloaded near the top must saturate, not wrap
        @(negedge clk);
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles_q;
        sc_exp = 32'hFFFF_FFFD;
        drive(1, 4'b0001, 0, 6'd0, 0, 32'h0, 6'b000011, 0, 0, 0, 32'h0, "sat_fd");
        drive(1, 4'b0001, 0, 6'd0, 0, 32'h0, 6'b000011, 0, 0, 0, 32'h0, "sat_fe");
        drive(1, 4'b0001, 0, 6'd0, 0, 32'h0, 6'b000011, 0, 0, 0, 32'h0, "sat_ff");
        drive(1, 4'b0001, 0, 6'd0, 0, 32'h0, 6'b000011, 0, 0, 0, 32'h0, "sat_hold1");
        drive(1, 4'b0000, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 32'h0, "sat_hold2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
